// File: rtl/hbm_channel_read_master.sv
// AXI4 read master for one HBM channel: splits a beat-count transfer into AR bursts
// and forwards R data to an AXI-Stream output, pulsing ctrl_done at the end.
module hbm_channel_read_master #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_XFER_WIDTH      = 32,
    parameter int C_BURST_LEN       = 64,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    ctrl_start,
    output logic                    ctrl_ready,
    input  logic [C_ADDR_WIDTH-1:0] ctrl_addr,
    input  logic [C_XFER_WIDTH-1:0] ctrl_beats,
    output logic                    ctrl_done,

    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]              m_axi_arlen,

    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    input  logic [C_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                    m_axi_rlast,

    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [C_DATA_WIDTH-1:0] m_tdata,
    output logic                    m_tlast
);

    localparam int                    BYTES_PER_BEAT = C_DATA_WIDTH / 8;
    localparam int                    OUT_W          = $clog2(C_MAX_OUTSTANDING) + 1;
    localparam logic [C_ADDR_WIDTH-1:0] BURST_BYTES  = C_ADDR_WIDTH'(C_BURST_LEN * BYTES_PER_BEAT);
    localparam logic [C_XFER_WIDTH-1:0] BURST_BEATS  = C_XFER_WIDTH'(C_BURST_LEN);
    localparam logic [C_XFER_WIDTH-1:0] XFER_ONE     = C_XFER_WIDTH'(1);
    localparam logic [OUT_W-1:0]        OUT_MAX      = OUT_W'(C_MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0]        OUT_ONE      = OUT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [C_ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]              arlen_q;
    logic [C_XFER_WIDTH-1:0] ar_rem;
    logic [C_XFER_WIDTH-1:0] ar_rem_nxt;
    logic [C_XFER_WIDTH-1:0] r_rem;
    logic [OUT_W-1:0]        outstanding;
    logic                    start_acc;
    logic                    ar_hs;
    logic                    r_hs;
    logic                    rlast_hs;

    function automatic logic [7:0] burst_len_m1(input logic [C_XFER_WIDTH-1:0] rem);
        if (rem >= BURST_BEATS)
            return 8'(C_BURST_LEN - 1);
        else if (rem == '0)
            return '0;
        else
            return 8'(rem - XFER_ONE);
    endfunction

    // R channel is a straight pass-through; only the beat counter taps it.
    assign m_tvalid     = m_axi_rvalid;
    assign m_axi_rready = m_tready;
    assign m_tdata      = m_axi_rdata;
    assign m_tlast      = (r_rem == XFER_ONE);

    assign m_axi_araddr = araddr_q;
    assign m_axi_arlen  = arlen_q;

    assign ar_hs      = m_axi_arvalid && m_axi_arready;
    assign r_hs       = m_axi_rvalid && m_tready;
    assign rlast_hs   = r_hs && m_axi_rlast;
    assign ar_rem_nxt = ar_rem - C_XFER_WIDTH'(arlen_q) - XFER_ONE;

    always_comb begin
        state_nxt     = state;
        ctrl_ready    = 1'b0;
        ctrl_done     = 1'b0;
        m_axi_arvalid = 1'b0;
        start_acc     = 1'b0;
        case (state)
            IDLE: begin
                ctrl_ready = 1'b1;
                if (ctrl_start) begin
                    start_acc = 1'b1;
                    state_nxt = (ctrl_beats != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                m_axi_arvalid = (ar_rem != '0) && (outstanding < OUT_MAX);
                if (ar_hs && ar_rem_nxt == '0)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (r_hs && r_rem == XFER_ONE)
                    state_nxt = DONE;
            end
            DONE: begin
                ctrl_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            araddr_q    <= '0;
            arlen_q     <= '0;
            ar_rem      <= '0;
            r_rem       <= '0;
            outstanding <= '0;
        end else begin
            state <= state_nxt;

            if (start_acc) begin
                araddr_q <= ctrl_addr;
                ar_rem   <= ctrl_beats;
                arlen_q  <= burst_len_m1(ctrl_beats);
            end else if (ar_hs) begin
                araddr_q <= araddr_q + BURST_BYTES;
                ar_rem   <= ar_rem_nxt;
                arlen_q  <= burst_len_m1(ar_rem_nxt);
            end

            if (start_acc)
                r_rem <= ctrl_beats;
            else if (r_hs && r_rem != '0)
                r_rem <= r_rem - XFER_ONE;

            // A burst issued and one retired in the same cycle cancel out.
            if (ar_hs && !rlast_hs)
                outstanding <= outstanding + OUT_ONE;
            else if (!ar_hs && rlast_hs && outstanding != '0)
                outstanding <= outstanding - OUT_ONE;
        end
    end

endmodule

// File: tb/tb_hbm_channel_read_master.sv
// Bench for hbm_channel_read_master: AXI slave model, AR/stream scoreboards,
// a vector table of transfers plus hand-written outstanding-limit and reset sequences.
module tb_hbm_channel_read_master;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int XW = 32;
    localparam int BL = 64;
    localparam int MO = 16;
    localparam int BB = DW / 8;
    localparam logic [63:0] BURST_BYTES = 64'(BL * BB);

    logic          clk = 1'b0;
    logic          rst;
    logic          ctrl_start;
    logic          ctrl_ready;
    logic [AW-1:0] ctrl_addr;
    logic [XW-1:0] ctrl_beats;
    logic          ctrl_done;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [DW-1:0] m_axi_rdata;
    logic          m_axi_rlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;

    always #5 clk = ~clk;

    hbm_channel_read_master #(
        .C_ADDR_WIDTH     (AW),
        .C_DATA_WIDTH     (DW),
        .C_XFER_WIDTH     (XW),
        .C_BURST_LEN      (BL),
        .C_MAX_OUTSTANDING(MO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_start   (ctrl_start),
        .ctrl_ready   (ctrl_ready),
        .ctrl_addr    (ctrl_addr),
        .ctrl_beats   (ctrl_beats),
        .ctrl_done    (ctrl_done),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arlen  (m_axi_arlen),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rlast  (m_axi_rlast),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tdata      (m_tdata),
        .m_tlast      (m_tlast)
    );

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [63:0] addr;
        int          beats;
        int          stall;
        bit          ar_rand;
        bit          t_rand;
        bit          r_rand;
        int          exp_ars;
    } vec_t;

    ar_t   exp_ar_q[$];
    beat_t exp_t_q[$];
    ar_t   slv_q[$];

    int checks = 0;
    int errors = 0;
    int ar_cnt = 0, rl_cnt = 0, t_cnt = 0, done_cnt = 0, coin_cnt = 0, tb_out = 0;
    int ar_hold = 0;
    int r_credit = 1 << 30;
    int bi = 0;
    bit ar_rand = 0, t_rand = 0, r_rand = 0, ar_mode = 0;

    logic        ar_hs, r_hs, t_hs, start_acc;
    logic        r_hs_prev = 0, arv_pend_prev = 0, final_prev = 0, zero_prev = 0, start_nz_prev = 0;
    logic [63:0] araddr_prev;
    logic [7:0]  arlen_prev;
    ar_t         a_pop;
    beat_t       b_pop;

    function automatic logic [DW-1:0] bdata(input logic [63:0] a);
        return {8{a ^ 64'h5A00_0000_0000_00C3}};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model drives at negedge+1, scoreboard/monitor samples at negedge+2.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            m_axi_arready = 1'b0;
            m_axi_rvalid  = 1'b0;
            m_axi_rlast   = 1'b0;
            m_tready      = 1'b1;
            slv_q.delete();
            bi = 0;
        end else begin
            m_tready = t_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!m_axi_rvalid || r_hs_prev) begin
                if (r_credit > 0 && slv_q.size() > 0 && !(r_rand && $urandom_range(0, 2) == 0)) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = bdata(slv_q[0].addr + 64'(bi * BB));
                    m_axi_rlast  = (bi == int'(slv_q[0].len));
                end else begin
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                end
            end
            if (ar_mode)
                m_axi_arready = m_axi_rvalid && m_axi_rlast && m_tready;
            else if (ar_hold > 0) begin
                m_axi_arready = 1'b0;
                ar_hold--;
            end else
                m_axi_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        #1;
        ar_hs     = m_axi_arvalid && m_axi_arready;
        r_hs      = m_axi_rvalid && m_axi_rready;
        t_hs      = m_tvalid && m_tready;
        start_acc = ctrl_start && ctrl_ready;
        if (rst) begin
            tb_out        = 0;
            r_hs_prev     = 0;
            arv_pend_prev = 0;
            final_prev    = 0;
            zero_prev     = 0;
            start_nz_prev = 0;
        end else begin
            check("tvalid_pass", m_tvalid, m_axi_rvalid);
            check("rready_pass", m_axi_rready, m_tready);
            if (m_tvalid) check("tdata_pass", m_tdata, m_axi_rdata);
            if (arv_pend_prev) begin
                check("arvalid_hold", m_axi_arvalid, 1'b1);
                check("araddr_stable", m_axi_araddr, araddr_prev);
                check("arlen_stable", m_axi_arlen, arlen_prev);
            end
            if (start_nz_prev) check("first_ar_latency", m_axi_arvalid, 1'b1);
            if (m_axi_arvalid) check("ar_outstanding_limit", tb_out < MO, 1'b1);
            check("done_timing", ctrl_done, final_prev || zero_prev);
            if (ctrl_done) done_cnt++;

            final_prev = 0;
            if (ar_hs) begin
                if (exp_ar_q.size() == 0) check("unexpected_ar", ar_hs, 1'b0);
                else begin
                    a_pop = exp_ar_q.pop_front();
                    check("araddr", m_axi_araddr, a_pop.addr);
                    check("arlen", m_axi_arlen, a_pop.len);
                end
                slv_q.push_back('{m_axi_araddr, m_axi_arlen});
                ar_cnt++;
                tb_out++;
            end
            if (t_hs) begin
                if (exp_t_q.size() == 0) check("unexpected_beat", t_hs, 1'b0);
                else begin
                    b_pop = exp_t_q.pop_front();
                    check("tdata", m_tdata, b_pop.data);
                    check("tlast", m_tlast, b_pop.last);
                    final_prev = b_pop.last;
                end
                t_cnt++;
            end
            if (r_hs) begin
                if (m_axi_rlast) begin
                    if (ar_hs) coin_cnt++;
                    void'(slv_q.pop_front());
                    bi = 0;
                    rl_cnt++;
                    tb_out--;
                    r_credit--;
                end else
                    bi++;
            end
            r_hs_prev     = r_hs;
            arv_pend_prev = m_axi_arvalid && !m_axi_arready;
            araddr_prev   = m_axi_araddr;
            arlen_prev    = m_axi_arlen;
            zero_prev     = start_acc && (ctrl_beats == '0);
            start_nz_prev = start_acc && (ctrl_beats != '0);
        end
    end

    task automatic push_expect(input logic [63:0] addr, input int beats);
        int rem;
        int n;
        logic [63:0] a;
        rem = beats;
        a   = addr;
        while (rem > 0) begin
            n = (rem > BL) ? BL : rem;
            exp_ar_q.push_back('{a, 8'(n - 1)});
            a   = a + BURST_BYTES;
            rem = rem - n;
        end
        for (int i = 0; i < beats; i++)
            exp_t_q.push_back('{bdata(addr + 64'(i * BB)), i == beats - 1});
    endtask

    // Start holds high one extra cycle with garbage fields; the busy DUT must ignore it.
    task automatic start_xfer(input logic [63:0] addr, input int beats, input int stall);
        push_expect(addr, beats);
        @(negedge clk);
        ctrl_addr  = addr;
        ctrl_beats = XW'(beats);
        ctrl_start = 1'b1;
        ar_hold    = (stall > 0) ? stall + 1 : 0;
        @(negedge clk);
        ctrl_addr  = ~addr;
        ctrl_beats = 7;
        #3 check("ready_busy", ctrl_ready, 1'b0);
        @(negedge clk);
        ctrl_start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int t = 0; t < 20000 && done_cnt == d0; t++) @(negedge clk);
        check("done_seen", done_cnt != d0, 1'b1);
    endtask

    task automatic wait_rlast(input int target);
        for (int t = 0; t < 500 && rl_cnt < target; t++) @(negedge clk);
        check("rlast_seen", rl_cnt >= target, 1'b1);
    endtask

    task automatic finish_xfer(input int d0, input int ar0, input int exp_ars);
        wait_done(d0);
        repeat (3) @(negedge clk);
        #3;
        check("done_once", done_cnt - d0, 1);
        check("ar_count", ar_cnt - ar0, exp_ars);
        check("ar_queue_empty", exp_ar_q.size(), 0);
        check("beat_queue_empty", exp_t_q.size(), 0);
        check("ready_idle", ctrl_ready, 1'b1);
    endtask

    vec_t vecs[7];
    int   d0, ar0, rl0, c0, t0;

    initial begin
        vecs[0] = '{64'h1000,    150, 0, 0, 0, 0, 3};
        vecs[1] = '{64'h0,         0, 0, 0, 0, 0, 0};
        vecs[2] = '{64'h4000,     64, 5, 0, 0, 0, 1};
        vecs[3] = '{64'h10000,   200, 0, 1, 1, 1, 4};
        vecs[4] = '{64'h8000,      1, 0, 0, 0, 0, 1};
        vecs[5] = '{64'h20000,  1024, 0, 1, 1, 1, 16};
        vecs[6] = '{64'h40000,    65, 0, 0, 1, 0, 2};

        rst        = 1'b1;
        ctrl_start = 1'b0;
        ctrl_addr  = '0;
        ctrl_beats = '0;
        repeat (3) @(negedge clk);
        #3;
        check("rst_ready", ctrl_ready, 1'b1);
        check("rst_done", ctrl_done, 1'b0);
        check("rst_arvalid", m_axi_arvalid, 1'b0);
        check("rst_araddr", m_axi_araddr, 64'h0);
        check("rst_arlen", m_axi_arlen, 8'h0);
        check("rst_tlast", m_tlast, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            ar_rand  = vecs[v].ar_rand;
            t_rand   = vecs[v].t_rand;
            r_rand   = vecs[v].r_rand;
            ar_mode  = 0;
            r_credit = 1 << 30;
            d0  = done_cnt;
            ar0 = ar_cnt;
            start_xfer(vecs[v].addr, vecs[v].beats, vecs[v].stall);
            finish_xfer(d0, ar0, vecs[v].exp_ars);
        end

        // Outstanding limit, refill after one retirement, and AR/rlast coincidence.
        ar_rand = 0; t_rand = 0; r_rand = 0; ar_mode = 0;
        r_credit = 0;
        d0 = done_cnt; ar0 = ar_cnt; rl0 = rl_cnt; c0 = coin_cnt;
        start_xfer(64'h100000, 64 * 20, 0);
        repeat (40) @(negedge clk);
        #3;
        check("ar_fill_limit", ar_cnt - ar0, 16);
        check("arvalid_at_limit", m_axi_arvalid, 1'b0);
        r_credit = 1;
        wait_rlast(rl0 + 1);
        repeat (10) @(negedge clk);
        #3;
        check("ar_after_rlast", ar_cnt - ar0, 17);
        check("arvalid_refilled", m_axi_arvalid, 1'b0);
        ar_mode  = 1;
        r_credit = 1;
        wait_rlast(rl0 + 2);
        repeat (5) @(negedge clk);
        #3;
        check("ar_held_for_coincide", ar_cnt - ar0, 17);
        check("arvalid_below_limit", m_axi_arvalid, 1'b1);
        r_credit = 1;
        wait_rlast(rl0 + 3);
        repeat (5) @(negedge clk);
        #3;
        check("coincident_hs", coin_cnt - c0, 1);
        check("ar_on_coincide", ar_cnt - ar0, 18);
        check("arvalid_after_coincide", m_axi_arvalid, 1'b1);
        ar_mode = 0;
        repeat (5) @(negedge clk);
        #3;
        check("ar_last_slot", ar_cnt - ar0, 19);
        check("arvalid_full_again", m_axi_arvalid, 1'b0);
        r_credit = 1 << 30;
        finish_xfer(d0, ar0, 20);

        // Reset in DRAIN aborts without a done pulse; the next transfer is clean.
        d0 = done_cnt; ar0 = ar_cnt; t0 = t_cnt;
        start_xfer(64'h200000, 640, 0);
        for (int t = 0; t < 2000 && t_cnt < t0 + 100; t++) @(negedge clk);
        #3;
        check("drain_reached", ar_cnt - ar0, 10);
        @(negedge clk);
        rst = 1'b1;
        exp_ar_q.delete();
        exp_t_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("abort_ready", ctrl_ready, 1'b1);
        check("abort_arvalid", m_axi_arvalid, 1'b0);
        check("abort_tlast", m_tlast, 1'b0);
        repeat (5) @(negedge clk);
        check("abort_no_done", done_cnt, d0);
        d0 = done_cnt; ar0 = ar_cnt;
        start_xfer(64'h300000, 100, 0);
        finish_xfer(d0, ar0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
